// File: rtl/wire_shark_onchip_memory_dp.sv
// wire_shark_onchip_memory_dp
// True-dual-port on-chip RAM with two Avalon-MM slave ports on one clock.
// s1 is the Nios data master side; s2 is the packet-capture DMA side.
// Storage is split into one 8-bit array per byte lane. Each lane has its own
// write port pair and a registered read per port, so byte enables map directly
// onto lane write enables.
// Both ports see OLD data on a same-cycle read/write of one address. If both
// ports write the same address in the same cycle, s1 wins on the lanes that
// both ports enable.
// Read latency is 1 clock-enabled cycle, plus one more when OUT_REG is set.
module wire_shark_onchip_memory_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    collision,
  output logic                    oob_err
);

  localparam int NB = DATA_WIDTH / 8;
  // Index width of the storage arrays. The address port may be wider.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH is compared one bit wider so that DEPTH == 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  en;

  // Per-port views of the slave signals. Index 0 is s1 and index 1 is s2.
  logic [ADDR_WIDTH-1:0] p_addr   [2];
  logic                  p_cs     [2];
  logic                  p_rd     [2];
  logic                  p_wr     [2];
  logic [NB-1:0]         p_be     [2];
  logic [DATA_WIDTH-1:0] p_wdata  [2];

  logic                  wr_req   [2];
  logic                  rd_req   [2];
  logic                  in_range [2];
  logic                  oob_hit  [2];
  logic [IW-1:0]         mem_idx  [2];
  logic [NB-1:0]         lane_we  [2];

  // Registered RAM read bytes, indexed [port][lane].
  logic [7:0]            ram_rd_q [2][NB];
  logic [DATA_WIDTH-1:0] ram_word    [2];
  logic [DATA_WIDTH-1:0] port_rdata  [2];
  logic                  port_rvalid [2];

  logic                  collision_d, collision_q;
  logic                  oob_err_d, oob_err_q;

  // A reset request stalls the block exactly like a dropped clock enable.
  assign en = clken & ~reset_req;

  assign p_addr[0]  = s1_address;
  assign p_addr[1]  = s2_address;
  assign p_cs[0]    = s1_chipselect;
  assign p_cs[1]    = s2_chipselect;
  assign p_rd[0]    = s1_read;
  assign p_rd[1]    = s2_read;
  assign p_wr[0]    = s1_write;
  assign p_wr[1]    = s2_write;
  assign p_be[0]    = s1_byteenable;
  assign p_be[1]    = s2_byteenable;
  assign p_wdata[0] = s1_writedata;
  assign p_wdata[1] = s2_writedata;

  genvar gi, gp;

  // Per-port request decode and read-return pipeline.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic rd_valid_d, rd_valid_q;

      // A strobe pair with write set is a write only.
      assign wr_req[gi]   = p_cs[gi] & p_wr[gi];
      assign rd_req[gi]   = p_cs[gi] & p_rd[gi] & ~p_wr[gi];
      assign in_range[gi] = ({1'b0, p_addr[gi]} < DEPTH_W);
      assign oob_hit[gi]  = (wr_req[gi] | rd_req[gi]) & ~in_range[gi];
      assign mem_idx[gi]  = p_addr[gi][IW-1:0];
      assign lane_we[gi]  = p_be[gi] & {NB{wr_req[gi] & in_range[gi]}};

      // Gather the per-lane read registers into one word.
      always_comb begin
        ram_word[gi] = '0;
        for (int b = 0; b < NB; b++) begin
          ram_word[gi][8*b +: 8] = ram_rd_q[gi][b];
        end
      end

      // First-stage valid: it advances only on enabled cycles.
      always_comb begin
        rd_valid_d = rd_valid_q;
        if (en) begin
          rd_valid_d = rd_req[gi];
        end
      end

      // First-stage valid register. Reset drops any read in flight.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_valid_d;
        end
      end

      if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
        logic                  out_valid_d, out_valid_q;

        // Output stage: capture data only when a read is returning, so the
        // last value stays on readdata while readdatavalid is low.
        always_comb begin
          out_data_d  = out_data_q;
          out_valid_d = out_valid_q;
          if (en) begin
            out_valid_d = rd_valid_q;
            if (rd_valid_q) begin
              out_data_d = ram_word[gi];
            end
          end
        end

        // Output stage register.
        always_ff @(posedge clk) begin
          if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
          end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
          end
        end

        assign port_rdata[gi]  = out_data_q;
        assign port_rvalid[gi] = out_valid_q;
      end else begin : g_no_out_reg
        // The RAM read register already holds its last value between reads.
        assign port_rdata[gi]  = ram_word[gi];
        assign port_rvalid[gi] = rd_valid_q;
      end
    end
  endgenerate

  // Byte-lane storage, each lane with two write ports and two read registers.
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      // Lane write. s2 is applied first so that s1 overrides it on a shared
      // address. Reset blocks writes, and the contents are never cleared.
      always_ff @(posedge clk) begin
        if (!reset && en) begin
          if (lane_we[1][gi]) begin
            mem[mem_idx[1]] <= p_wdata[1][8*gi +: 8];
          end
          if (lane_we[0][gi]) begin
            mem[mem_idx[0]] <= p_wdata[0][8*gi +: 8];
          end
        end
      end

      for (gp = 0; gp < 2; gp++) begin : g_rd
        // Registered lane read. It samples before this edge's writes, which
        // gives old data. An out-of-range read returns zero.
        always_ff @(posedge clk) begin
          if (reset) begin
            ram_rd_q[gp][gi] <= 8'h00;
          end else if (en && rd_req[gp]) begin
            ram_rd_q[gp][gi] <= in_range[gp] ? mem[mem_idx[gp]] : 8'h00;
          end
        end
      end
    end
  endgenerate

  // Collision and sticky out-of-range detection.
  always_comb begin
    collision_d = en & wr_req[0] & wr_req[1] & in_range[0] & in_range[1] &
                  (p_addr[0] == p_addr[1]);
    oob_err_d   = oob_err_q;
    if (en && (oob_hit[0] || oob_hit[1])) begin
      oob_err_d = 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q <= 1'b0;
      oob_err_q   <= 1'b0;
    end else begin
      collision_q <= collision_d;
      oob_err_q   <= oob_err_d;
    end
  end

  // collision never shows while the block is stalled.
  assign collision        = collision_q & en;
  assign oob_err          = oob_err_q;
  assign s1_readdata      = port_rdata[0];
  assign s1_readdatavalid = port_rvalid[0];
  assign s2_readdata      = port_rdata[1];
  assign s2_readdatavalid = port_rvalid[1];

endmodule

// File: tb/tb_wire_shark_onchip_memory_dp.sv
// Bench for wire_shark_onchip_memory_dp. Two instances share all inputs:
// dut0 uses latency 1 and dut1 uses latency 2, both with DEPTH=3000.
// The reference model keeps a word-level memory and a timeline of reads,
// indexed by enabled cycle. Each expected output is found by looking back
// L-1 enabled cycles in that timeline.
module tb_wire_shark_onchip_memory_dp;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 3000;
  localparam int RECN  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clken, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [NB-1:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;

  logic [DW-1:0] d0_s1_readdata, d0_s2_readdata, d1_s1_readdata, d1_s2_readdata;
  logic          d0_s1_readdatavalid, d0_s2_readdatavalid;
  logic          d1_s1_readdatavalid, d1_s2_readdatavalid;
  logic          d0_collision, d0_oob_err, d1_collision, d1_oob_err;

  wire_shark_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(d0_s1_readdata), .s1_readdatavalid(d0_s1_readdatavalid),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(d0_s2_readdata), .s2_readdatavalid(d0_s2_readdatavalid),
    .collision(d0_collision), .oob_err(d0_oob_err)
  );

  wire_shark_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(d1_s1_readdata), .s1_readdatavalid(d1_s1_readdatavalid),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(d1_s2_readdata), .s2_readdatavalid(d1_s2_readdatavalid),
    .collision(d1_collision), .oob_err(d1_oob_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DW-1:0] mem_m  [DEPTH];
  logic [DW-1:0] rec_d  [2][RECN];
  bit            rec_v  [2][RECN];
  int            en_cnt = 0;
  int            base   = 1;
  logic [DW-1:0] exp_rd [2][2];
  bit            exp_v  [2][2];
  bit            exp_coll = 1'b0;
  bit            exp_oob  = 1'b0;

  // Observed {valid, data} of instance k, port p (0 = s1, 1 = s2).
  function automatic logic [DW:0] obs(input int k, input int p);
    logic [DW:0] r;
    r = '0;
    if (k == 0 && p == 0) r = {d0_s1_readdatavalid, d0_s1_readdata};
    if (k == 0 && p == 1) r = {d0_s2_readdatavalid, d0_s2_readdata};
    if (k == 1 && p == 0) r = {d1_s1_readdatavalid, d1_s1_readdata};
    if (k == 1 && p == 1) r = {d1_s2_readdatavalid, d1_s2_readdata};
    return r;
  endfunction

  function automatic logic [1:0] obs_flags(input int k);
    return (k == 0) ? {d0_collision, d0_oob_err} : {d1_collision, d1_oob_err};
  endfunction

  task automatic drive(input int port, input logic cs, input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input logic [NB-1:0] be, input logic [DW-1:0] wd);
    if (port == 0) begin
      s1_chipselect = cs; s1_read = rd; s1_write = wr;
      s1_address = addr; s1_byteenable = be; s1_writedata = wd;
    end else begin
      s2_chipselect = cs; s2_read = rd; s2_write = wr;
      s2_address = addr; s2_byteenable = be; s2_writedata = wd;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    logic [AW-1:0] a   [2];
    logic [NB-1:0] be  [2];
    logic [DW-1:0] wd  [2];
    bit            w   [2];
    bit            r   [2];
    bit            inr [2];
    int            idx;
    a[0] = s1_address; a[1] = s2_address;
    be[0] = s1_byteenable; be[1] = s2_byteenable;
    wd[0] = s1_writedata; wd[1] = s2_writedata;
    w[0] = s1_chipselect && s1_write;
    w[1] = s2_chipselect && s2_write;
    r[0] = s1_chipselect && s1_read && !s1_write;
    r[1] = s2_chipselect && s2_read && !s2_write;
    @(posedge clk);
    if (reset) begin
      base     = en_cnt + 1;
      exp_coll = 1'b0;
      exp_oob  = 1'b0;
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          exp_rd[k][p] = '0;
          exp_v[k][p]  = 1'b0;
        end
      end
    end else if (clken && !reset_req) begin
      en_cnt++;
      for (int p = 0; p < 2; p++) begin
        inr[p] = int'(a[p]) < DEPTH;
        rec_v[p][en_cnt] = r[p];
        rec_d[p][en_cnt] = inr[p] ? mem_m[a[p]] : '0;
      end
      for (int p = 1; p >= 0; p--) begin
        if (w[p] && inr[p]) begin
          for (int b = 0; b < NB; b++) begin
            if (be[p][b]) mem_m[a[p]][8*b +: 8] = wd[p][8*b +: 8];
          end
        end
      end
      exp_coll = w[0] && w[1] && inr[0] && inr[1] && (a[0] == a[1]);
      for (int p = 0; p < 2; p++) begin
        if ((w[p] || r[p]) && !inr[p]) exp_oob = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        idx = en_cnt - k;
        for (int p = 0; p < 2; p++) begin
          if (idx >= base && rec_v[p][idx]) begin
            exp_v[k][p]  = 1'b1;
            exp_rd[k][p] = rec_d[p][idx];
          end else begin
            exp_v[k][p] = 1'b0;
          end
        end
      end
    end else begin
      exp_coll = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    $display("txn reset: two reset cycles");
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (obs(k, p) !== '0) begin
          n_fail++;
          $display("FAIL reset_out dut%0d port%0d: got %h want 0", k, p + 1, obs(k, p));
        end
      end
      n_checks++;
      if (obs_flags(k) !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d: got %b want 00", k, obs_flags(k));
      end
    end
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 1'b0, 1'b1, 12'd5, 4'hF, 32'hDEADBEEF); tick();
    $display("txn s1 write addr 5 = deadbeef");
    idle(); drive(0, 1'b1, 1'b1, 1'b0, 12'd5, '0, '0); tick();
    $display("txn s1 read addr 5");
    n_checks++;
    if (obs(0, 0) !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_rd_l1: got %h want 1deadbeef", obs(0, 0));
    end
    n_checks++;
    if (d1_s1_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_rd_l2_early: got %b want 0", d1_s1_readdatavalid);
    end
    idle(); tick();
    n_checks++;
    if (obs(0, 0) !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_rd_l1_hold: got %h want 0deadbeef", obs(0, 0));
    end
    n_checks++;
    if (obs(1, 0) !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_rd_l2: got %h want 1deadbeef", obs(1, 0));
    end
    tick();
    n_checks++;
    if (obs(1, 0) !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_rd_l2_single: got %h want 0deadbeef", obs(1, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b0, 1'b1, AW'(i), 4'hF, 32'(16 + i)); tick();
      $display("txn s2 preload addr %0d", i);
    end
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive(1, 1'b1, 1'b1, 1'b0, AW'(t), '0, '0);
      else idle();
      tick();
      $display("txn b2b cycle %0d: d1 s2 valid=%b data=%h", t, d1_s2_readdatavalid, d1_s2_readdata);
      want = 32'(16 + t - 1);
      n_checks++;
      if ((t >= 1 && t <= 4) ? (obs(1, 1) !== {1'b1, want}) : (d1_s2_readdatavalid !== 1'b0)) begin
        n_fail++; $display("FAIL b2b_l2 cycle %0d: got %h want valid=%0d data %h", t, obs(1, 1), (t >= 1 && t <= 4), want);
      end
      want = 32'(16 + t);
      n_checks++;
      if ((t <= 3) ? (obs(0, 1) !== {1'b1, want}) : (d0_s2_readdatavalid !== 1'b0)) begin
        n_fail++; $display("FAIL b2b_l1 cycle %0d: got %h want valid=%0d data %h", t, obs(0, 1), (t <= 3), want);
      end
    end
  endtask

  task automatic test_byte_lanes();
    idle(); drive(0, 1'b1, 1'b0, 1'b1, 12'd20, 4'hF, 32'h11223344); tick();
    drive(0, 1'b1, 1'b0, 1'b1, 12'd20, 4'b0101, 32'hAABBCCDD); tick();
    drive(0, 1'b1, 1'b1, 1'b0, 12'd20, '0, '0); tick();
    $display("txn byte lanes addr 20: read %h", d0_s1_readdata);
    n_checks++;
    if (obs(0, 0) !== {1'b1, 32'h11BB33DD}) begin
      n_fail++; $display("FAIL byte_lanes: got %h want 111bb33dd", obs(0, 0));
    end
    idle(); tick();
    n_checks++;
    if (obs(1, 0) !== {1'b1, 32'h11BB33DD}) begin
      n_fail++; $display("FAIL byte_lanes_l2: got %h want 111bb33dd", obs(1, 0));
    end
  endtask

  task automatic test_collision();
    idle(); drive(0, 1'b1, 1'b0, 1'b1, 12'd9, 4'hF, 32'h0); tick();
    drive(0, 1'b1, 1'b0, 1'b1, 12'd9, 4'b0001, 32'h000000FF);
    drive(1, 1'b1, 1'b0, 1'b1, 12'd9, 4'b0011, 32'h12345678);
    tick();
    $display("txn collision addr 9: d0=%b d1=%b", d0_collision, d1_collision);
    n_checks++;
    if ({d0_collision, d1_collision} !== 2'b11) begin
      n_fail++; $display("FAIL collision_pulse: got %b want 11", {d0_collision, d1_collision});
    end
    idle(); drive(0, 1'b1, 1'b1, 1'b0, 12'd9, '0, '0); tick();
    n_checks++;
    if ({d0_collision, d1_collision} !== 2'b00) begin
      n_fail++; $display("FAIL collision_one_cycle: got %b want 00", {d0_collision, d1_collision});
    end
    n_checks++;
    if (obs(0, 0) !== {1'b1, 32'h000056FF}) begin
      n_fail++; $display("FAIL collision_merge: got %h want 1000056ff", obs(0, 0));
    end
    idle(); tick();
  endtask

  task automatic test_rdw();
    idle(); drive(0, 1'b1, 1'b0, 1'b1, 12'd7, 4'hF, 32'h1); tick();
    drive(0, 1'b1, 1'b0, 1'b1, 12'd7, 4'hF, 32'h2);
    drive(1, 1'b1, 1'b1, 1'b0, 12'd7, '0, '0);
    tick();
    $display("txn rdw: s2 read addr 7 while s1 writes 2 -> %h", d0_s2_readdata);
    n_checks++;
    if (obs(0, 1) !== {1'b1, 32'h1}) begin
      n_fail++; $display("FAIL rdw_old: got %h want 100000001", obs(0, 1));
    end
    idle(); drive(1, 1'b1, 1'b1, 1'b0, 12'd7, '0, '0); tick();
    n_checks++;
    if (obs(0, 1) !== {1'b1, 32'h2}) begin
      n_fail++; $display("FAIL rdw_new: got %h want 100000002", obs(0, 1));
    end
    n_checks++;
    if (obs(1, 1) !== {1'b1, 32'h1}) begin
      n_fail++; $display("FAIL rdw_old_l2: got %h want 100000001", obs(1, 1));
    end
    idle(); tick();
    n_checks++;
    if (obs(1, 1) !== {1'b1, 32'h2}) begin
      n_fail++; $display("FAIL rdw_new_l2: got %h want 100000002", obs(1, 1));
    end
  endtask

  task automatic test_stall();
    idle(); drive(0, 1'b1, 1'b1, 1'b0, 12'd5, '0, '0); tick();
    $display("txn stall: s1 read addr 5 then clken low 3 cycles");
    idle(); clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (d1_s1_readdatavalid !== 1'b0 || d1_collision !== 1'b0) begin
        n_fail++; $display("FAIL stall_l2_held %0d: got valid %b coll %b want 0 0", i, d1_s1_readdatavalid, d1_collision);
      end
      n_checks++;
      if (obs(0, 0) !== {1'b1, 32'hDEADBEEF}) begin
        n_fail++; $display("FAIL stall_l1_hold %0d: got %h want 1deadbeef", i, obs(0, 0));
      end
    end
    clken = 1'b1; tick();
    n_checks++;
    if (obs(1, 0) !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL stall_l2_release: got %h want 1deadbeef", obs(1, 0));
    end
    n_checks++;
    if (d0_s1_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL stall_l1_drop: got %b want 0", d0_s1_readdatavalid);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    idle(); drive(0, 1'b1, 1'b1, 1'b0, 12'd5, '0, '0); tick();
    $display("txn reset in flight: read addr 5 then reset");
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs(1, 0) !== '0 || obs(0, 0) !== '0) begin
        n_fail++; $display("FAIL reset_drop %0d: got d1 %h d0 %h want 0 0", i, obs(1, 0), obs(0, 0));
      end
      tick();
    end
  endtask

  task automatic test_oob();
    idle(); drive(0, 1'b1, 1'b1, 1'b0, 12'd5, '0, '0); tick();
    n_checks++;
    if ({d0_oob_err, d1_oob_err} !== 2'b00) begin
      n_fail++; $display("FAIL oob_clear: got %b want 00", {d0_oob_err, d1_oob_err});
    end
    drive(0, 1'b1, 1'b1, 1'b0, 12'd3000, '0, '0); tick();
    $display("txn oob: s1 read addr 3000 -> %h", d0_s1_readdata);
    n_checks++;
    if (obs(0, 0) !== {1'b1, 32'h0} || {d0_oob_err, d1_oob_err} !== 2'b11) begin
      n_fail++; $display("FAIL oob_read: got %h oob %b want 100000000 11", obs(0, 0), {d0_oob_err, d1_oob_err});
    end
    drive(0, 1'b1, 1'b0, 1'b1, 12'd2999, 4'hF, 32'hCAFEF00D);
    drive(1, 1'b1, 1'b0, 1'b1, 12'd3000, 4'hF, 32'h55AA55AA);
    tick();
    n_checks++;
    if (obs(1, 0) !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL oob_read_l2: got %h want 100000000", obs(1, 0));
    end
    idle(); drive(0, 1'b1, 1'b1, 1'b0, 12'd2999, '0, '0); tick();
    n_checks++;
    if (obs(0, 0) !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL oob_last_word: got %h want 1cafef00d", obs(0, 0));
    end
    idle(); tick(); tick(); tick();
    n_checks++;
    if ({d0_oob_err, d1_oob_err} !== 2'b11) begin
      n_fail++; $display("FAIL oob_sticky: got %b want 11", {d0_oob_err, d1_oob_err});
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({d0_oob_err, d1_oob_err} !== 2'b00) begin
      n_fail++; $display("FAIL oob_reset: got %b want 00", {d0_oob_err, d1_oob_err});
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 7) return AW'($urandom_range(0, 15));
    if (s == 7) return AW'(2999);
    return AW'(3000 + $urandom_range(0, 7));
  endfunction

  task automatic test_random();
    int op;
    idle();
    for (int i = 0; i < 17; i++) begin
      drive(0, 1'b1, 1'b0, 1'b1, (i == 16) ? AW'(2999) : AW'(i), 4'hF, DW'($urandom));
      tick();
    end
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) < 2);
      clken     = ($urandom_range(0, 99) < 90);
      reset_req = ($urandom_range(0, 99) < 5);
      for (int p = 0; p < 2; p++) begin
        op = $urandom_range(0, 4);
        case (op)
          1: drive(p, 1'b1, 1'b1, 1'b0, rnd_addr(), NB'($urandom), DW'($urandom));
          2: drive(p, 1'b1, 1'b0, 1'b1, rnd_addr(), NB'($urandom), DW'($urandom));
          3: drive(p, 1'b1, 1'b1, 1'b1, rnd_addr(), NB'($urandom), DW'($urandom));
          4: drive(p, 1'b0, 1'b1, 1'b0, rnd_addr(), NB'($urandom), DW'($urandom));
          default: drive(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        endcase
      end
      // Same-address writes are made more likely so collisions occur.
      if ($urandom_range(0, 7) == 0) s2_address = s1_address;
      tick();
      $display("txn rand %0d: rst=%b en=%b s1 cs=%b rd=%b wr=%b a=%0d s2 cs=%b rd=%b wr=%b a=%0d",
               c, reset, clken && !reset_req, s1_chipselect, s1_read, s1_write, s1_address,
               s2_chipselect, s2_read, s2_write, s2_address);
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++) begin
          n_checks++;
          if (obs(k, p) !== {exp_v[k][p], exp_rd[k][p]}) begin
            n_fail++;
            $display("FAIL rand_port cyc %0d dut%0d port%0d: got %h want %h", c, k, p + 1, obs(k, p), {exp_v[k][p], exp_rd[k][p]});
          end
        end
        n_checks++;
        if (obs_flags(k) !== {exp_coll, exp_oob}) begin
          n_fail++;
          $display("FAIL rand_flags cyc %0d dut%0d: got %b want %b", c, k, obs_flags(k), {exp_coll, exp_oob});
        end
      end
    end
    reset = 1'b0; clken = 1'b1; reset_req = 1'b0; idle(); tick();
  endtask

  initial begin
    reset = 1'b0; clken = 1'b1; reset_req = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_byte_lanes();
    test_collision();
    test_rdw();
    test_stall();
    test_reset_inflight();
    test_oob();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wire_shark_onchip_memory_dp.md
Name: wire_shark_onchip_memory_dp

Overview:
Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) sharing one clock. It succeeds the single-port Nios on-chip memory. Additions:
- configurable width, depth and read latency
- explicit readdatavalid
- defined cross-port collision resolution
- out-of-range address detection

It sits between the Nios data master (s1) and the packet-capture DMA (s2), so captured frames can be handed to software without a copy.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 12, word-address width per port.
DEPTH, 4096, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
clk  in  1  single clock for both ports and all state.
reset  in  1  synchronous, active-high reset.
clken  in  1  global clock enable.
reset_req  in  1  reset-request hold-off; when high the block behaves as if clken=0.
s1_address  in  ADDR_WIDTH  port 1 word address.
s1_chipselect  in  1  port 1 select.
s1_read  in  1  port 1 read strobe.
s1_write  in  1  port 1 write strobe.
s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes.
s1_writedata  in  DATA_WIDTH  port 1 write data.
s1_readdata  out  DATA_WIDTH  port 1 read data.
s1_readdatavalid  out  1  port 1 read data qualifier.
s2_*  (same set as s1)  port 2, identical semantics.
collision  out  1  one-cycle pulse: both ports wrote the same in-range address in the same cycle.
oob_err  out  1  sticky: an access was made at address >= DEPTH.

Behaviour:
- Enable: en = clken & ~reset_req.
  - en=0: no memory write, no pipeline advance; all outputs hold, except collision, which is forced to 0.
- Reset:
  - Synchronous; overrides en.
  - Clears s*_readdata to 0, s*_readdatavalid to 0, the read pipeline, collision and oob_err.
  - RAM contents are not cleared.
  - Reads in flight when reset asserts are dropped and never produce readdatavalid.
- No waitrequest: every request is accepted on the en cycle in which it is presented.
- Port request decode, per port:
  - wr = chipselect & write.
  - rd = chipselect & read & ~write; read and write asserted together is treated as a write only.
- Writes: on an en edge, byte lane i of mem[address] is updated when byteenable[i]=1.
- Read latency L = 1 + OUT_REG, counted in en cycles.
  - A read accepted at en-edge N presents data with readdatavalid=1 at en-edge N+L.
  - readdatavalid is high exactly one en-cycle per accepted read.
  - Back-to-back reads give continuous valid.
  - readdata holds its last value when readdatavalid=0.
- Read-during-write, same address, same cycle, either port combination: the read returns OLD data.
- Simultaneous writes to the same in-range address:
  - Per byte lane, s1 wins where both ports enable the lane.
  - s2 data is written on lanes enabled only by s2.
  - collision pulses high for the following cycle (registered).
- Out-of-range address (address >= DEPTH) with wr or rd:
  - The write is discarded.
  - The read still produces readdatavalid with readdata = 0.
  - oob_err is set and stays set until reset.
- Ports are fully independent apart from the collision rule.

Test Plan:
- OUT_REG=0: s1 writes 0xDEADBEEF to addr 5, then reads addr 5 → s1_readdatavalid=1 exactly 1 cycle after the read, readdata=0xDEADBEEF.
- OUT_REG=1: s2 issues 4 back-to-back reads of addrs 0..3, preloaded with 0x10..0x13 → valid for 4 consecutive cycles starting 2 cycles after the first read, data 0x10,0x11,0x12,0x13.
- Byte lanes: s1 writes 0xAABBCCDD with byteenable=4'b0101 over 0x11223344 → subsequent read returns 0x11BB33DD.
- Collision: in the same cycle s1 writes 0x000000FF (be=0001) and s2 writes 0x12345678 (be=0011) to addr 9 → mem[9] low 16 bits = 0x56FF, collision=1 for one cycle.
- Cross-port read-during-write: s2 reads addr 7 (holding 0x1) while s1 writes 0x2 to addr 7 → s2 gets 0x1, a later read gets 0x2.
- Stall, reset and range:
  - Read issued, then clken=0 for 3 cycles → valid delayed by 3 cycles.
  - Reset asserted in the cycle after a read → no valid.
  - With DEPTH=3000, access to address 3000 → readdata=0, oob_err=1 until reset.
